task_dispatcher: RTL

TASK_DISPATCHER -- requirements
Module: task_dispatcher

---
 rtl/sched_pkg.sv | 31 +++
 rtl/prio_select.sv | 40 ++++
 rtl/task_dispatcher.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// Shared definitions for the task dispatcher: op-word layout, opcodes and FSM states.
package sched_pkg;

  localparam int unsigned IdxW = 4;

  localparam int unsigned OpIdLsb   = 8;
  localparam int unsigned OpCodeLsb = 4;
  localparam int unsigned OpArgLsb  = 0;

  localparam logic [3:0]  OpExecute = 4'b0111;
  localparam logic [3:0]  OpFinish  = 4'b1111;
  localparam logic [15:0] OpNop     = 16'h0000;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StDispatch,
    StRun,
    StFinish
  } state_e;

  function automatic logic [15:0] make_op(input logic [3:0] id, input logic [3:0] code);
    return {4'h0, id, code, 4'h0};
  endfunction

  // Execute and Finish belong to the dispatcher; a host may not forge them.
  function automatic logic is_reserved(input logic [15:0] op);
    return (op[OpCodeLsb +: 4] == OpExecute) || (op[OpCodeLsb +: 4] == OpFinish);
  endfunction

endpackage

// File: rtl/prio_select.sv
// Combinational winner pick: lowest priority value wins, ties go to the first slot
// in round-robin order starting at i_rr_start.
module prio_select
  import sched_pkg::*;
#(
  parameter int unsigned N_TASKS = 8
) (
  input  logic [8*N_TASKS-1:0] i_sorter_in,
  input  logic [IdxW-1:0]      i_rr_start,
  output logic [IdxW-1:0]      o_win_idx,
  output logic [3:0]           o_win_id,
  output logic                 o_win_valid
);

  int unsigned w_idx;
  logic [7:0]  w_slot;
  logic [3:0]  w_best_prio;

  always_comb begin
    o_win_idx   = '0;
    o_win_id    = '0;
    o_win_valid = 1'b0;
    w_best_prio = 4'hF;
    w_idx       = 0;
    w_slot      = 8'h00;
    for (int unsigned k = 0; k < N_TASKS; k++) begin
      w_idx = int'(i_rr_start) + k;
      if (w_idx >= N_TASKS) w_idx = w_idx - N_TASKS;
      w_slot = i_sorter_in[8*w_idx +: 8];
      // Strict compare keeps the earliest slot in scan order on a tie.
      if ((w_slot != 8'h00) && (!o_win_valid || (w_slot[3:0] < w_best_prio))) begin
        o_win_valid = 1'b1;
        o_win_idx   = IdxW'(w_idx);
        o_win_id    = w_slot[7:4];
        w_best_prio = w_slot[3:0];
      end
    end
  end

endmodule

// File: rtl/task_dispatcher.sv
// Time-slice task dispatcher: picks a ready task, issues Execute, runs a slice,
// issues Finish, and forwards host operation words in between.
module task_dispatcher
  import sched_pkg::*;
#(
  parameter int unsigned N_TASKS      = 8,
  parameter int unsigned SLICE_CYCLES = 10000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [8*N_TASKS-1:0] sorter_in,
  input  logic                 host_op_valid,
  input  logic [15:0]          host_op,
  output logic                 host_op_ready,
  output logic [15:0]          out_op,
  output logic [3:0]           cur_id,
  output logic                 running,
  output logic                 slice_end
);

  localparam logic [15:0]     SliceLast = 16'(SLICE_CYCLES - 1);
  localparam logic [IdxW-1:0] LastSlot  = IdxW'(N_TASKS - 1);

  state_e          r_state, w_state_nxt;
  logic [IdxW-1:0] r_win_idx, w_win_idx_nxt;
  logic [3:0]      r_win_id, w_win_id_nxt;
  logic [IdxW-1:0] r_last_idx, w_last_idx_nxt;
  logic [15:0]     r_cnt, w_cnt_nxt;
  logic [15:0]     r_out_op, w_out_op_nxt;
  logic [3:0]      r_cur_id, w_cur_id_nxt;
  logic            r_running, w_running_nxt;
  logic            r_slice_end, w_slice_end_nxt;
  logic            r_ready, w_ready_nxt;

  logic [IdxW-1:0] w_rr_start;
  logic [IdxW-1:0] w_sel_idx;
  logic [3:0]      w_sel_id;
  logic            w_sel_valid;
  logic [7:0]      w_cur_slot;
  logic            w_host_accept;

  assign w_rr_start    = (r_last_idx == LastSlot) ? '0 : r_last_idx + IdxW'(1);
  assign w_cur_slot    = sorter_in[8*r_win_idx +: 8];
  assign w_host_accept = host_op_valid && r_ready;

  prio_select #(
    .N_TASKS (N_TASKS)
  ) u_prio_select (
    .i_sorter_in (sorter_in),
    .i_rr_start  (w_rr_start),
    .o_win_idx   (w_sel_idx),
    .o_win_id    (w_sel_id),
    .o_win_valid (w_sel_valid)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_win_idx_nxt   = r_win_idx;
    w_win_id_nxt    = r_win_id;
    w_last_idx_nxt  = r_last_idx;
    w_cnt_nxt       = r_cnt;
    w_out_op_nxt    = OpNop;
    w_cur_id_nxt    = r_cur_id;
    w_running_nxt   = r_running;
    w_slice_end_nxt = 1'b0;

    if (w_host_accept && !is_reserved(host_op)) w_out_op_nxt = host_op;

    unique case (r_state)
      StIdle: begin
        w_running_nxt = 1'b0;
        w_cur_id_nxt  = 4'h0;
        if (|sorter_in) w_state_nxt = StSelect;
      end
      StSelect: begin
        w_running_nxt = 1'b0;
        w_cur_id_nxt  = 4'h0;
        if (w_sel_valid) begin
          w_state_nxt   = StDispatch;
          w_win_idx_nxt = w_sel_idx;
          w_win_id_nxt  = w_sel_id;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StDispatch: begin
        w_out_op_nxt   = make_op(r_win_id, OpExecute);
        w_running_nxt  = 1'b1;
        w_cur_id_nxt   = r_win_id;
        w_cnt_nxt      = '0;
        w_last_idx_nxt = r_win_idx;
        w_state_nxt    = StRun;
      end
      StRun: begin
        // A vanished slot ends the slice silently, even on its last cycle.
        if (w_cur_slot == 8'h00) begin
          w_state_nxt     = StSelect;
          w_slice_end_nxt = 1'b1;
          w_running_nxt   = 1'b0;
          w_cur_id_nxt    = 4'h0;
        end else if (r_cnt == SliceLast) begin
          w_state_nxt = StFinish;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      StFinish: begin
        w_out_op_nxt    = make_op(r_cur_id, OpFinish);
        w_slice_end_nxt = 1'b1;
        w_state_nxt     = StSelect;
      end
      default: w_state_nxt = StIdle;
    endcase

    // Ready is withheld exactly while the dispatcher owns the op bus.
    w_ready_nxt = (w_state_nxt != StDispatch) && (w_state_nxt != StFinish);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= StIdle;
      r_win_idx   <= '0;
      r_win_id    <= 4'h0;
      r_last_idx  <= LastSlot;
      r_cnt       <= '0;
      r_out_op    <= OpNop;
      r_cur_id    <= 4'h0;
      r_running   <= 1'b0;
      r_slice_end <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_win_idx   <= w_win_idx_nxt;
      r_win_id    <= w_win_id_nxt;
      r_last_idx  <= w_last_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_op    <= w_out_op_nxt;
      r_cur_id    <= w_cur_id_nxt;
      r_running   <= w_running_nxt;
      r_slice_end <= w_slice_end_nxt;
      r_ready     <= w_ready_nxt;
    end
  end

  assign out_op        = r_out_op;
  assign cur_id        = r_cur_id;
  assign running       = r_running;
  assign slice_end     = r_slice_end;
  assign host_op_ready = r_ready;

endmodule
